reaction_fsm: RTL and testbench

Top-level control state machine of the reaction timer, directly downstream of the countdown/random-delay generator. It drives the 3-bit state code `fState` that the generator consumes. It watches the generator's `counter_321` and `randomTime` outputs to decide when the stimulus fires. It then measures the player's reaction time in clock ticks (1 tick = 1 ms) and keeps the session best time for the display stage.

---
 rtl/reaction_fsm_if.sv | 34 +++
 rtl/reaction_fsm.sv | 119 +++++++++++
 tb/tb_reaction_fsm.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_fsm_if.sv
// Reaction timer control bus: buttons and generator outputs in, state and
// timing results out.
//   master : bench or upstream logic (drives buttons and generator values)
//   slave  : reaction_fsm
interface reaction_fsm_if #(
    parameter int unsigned TIME_W = 14
);
    localparam int unsigned CNT_W = 12;
    localparam int unsigned RND_W = 13;

    logic              pushButton1;
    logic              pushButton2;
    logic [CNT_W-1:0]  counter_321;
    logic [RND_W-1:0]  randomTime;
    logic [2:0]        fState;
    logic [1:0]        countdownDigit;
    logic              stimulusLed;
    logic [TIME_W-1:0] reactionTime;
    logic [TIME_W-1:0] bestTime;
    logic              tooEarly;
    logic              newBest;

    modport master (
        output pushButton1, pushButton2, counter_321, randomTime,
        input  fState, countdownDigit, stimulusLed, reactionTime, bestTime,
               tooEarly, newBest
    );

    modport slave (
        input  pushButton1, pushButton2, counter_321, randomTime,
        output fState, countdownDigit, stimulusLed, reactionTime, bestTime,
               tooEarly, newBest
    );
endinterface

// File: rtl/reaction_fsm.sv
// Reaction timer control FSM. Sequences IDLE -> PREP (countdown + random
// delay) -> TEST (stimulus on, count ms) -> RESULT, or EARLY on a premature
// press, and keeps the best valid reaction time since reset.
// Ports:
//   clk : 1 kHz tick clock
//   rst : synchronous active-high reset
//   bus : reaction_fsm_if.slave (buttons/generator in, state/results out)
module reaction_fsm #(
    parameter int unsigned MAX_TIME = 9999,
    parameter int unsigned TIME_W   = 14
) (
    input  logic          clk,
    input  logic          rst,
    reaction_fsm_if.slave bus
);
    localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_PREP   = 3'b001,
        S_TEST   = 3'b010,
        S_RESULT = 3'b011,
        S_EARLY  = 3'b100
    } state_e;

    state_e            state_q, state_d;
    logic [TIME_W-1:0] cnt_q, cnt_d;
    logic [TIME_W-1:0] reaction_q, reaction_d;
    logic [TIME_W-1:0] best_q, best_d;
    logic              new_best_q, new_best_d;
    logic              pb1_prev_q, pb2_prev_q;
    logic              pb1_rise, pb2_rise;
    logic [1:0]        digit;

    // Rising edges; previous levels reset high so a held button is not an edge
    assign pb1_rise = bus.pushButton1 & ~pb1_prev_q;
    assign pb2_rise = bus.pushButton2 & ~pb2_prev_q;

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reaction_d = reaction_q;
        best_d     = best_q;
        new_best_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pb1_rise) state_d = S_PREP;
            end
            S_PREP: begin
                if (pb2_rise) begin
                    state_d = S_EARLY;
                end else if ((bus.counter_321 < 12'd3) && (bus.randomTime == 13'd0)) begin
                    state_d = S_TEST;
                    cnt_d   = '0;
                end
            end
            S_TEST: begin
                // A press landing on the saturated count is a timeout, not a best
                if (pb2_rise || (cnt_q == MAX_T)) begin
                    reaction_d = cnt_q;
                    state_d    = S_RESULT;
                    if (pb2_rise && (cnt_q != MAX_T) && (cnt_q < best_q)) begin
                        best_d     = cnt_q;
                        new_best_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + TIME_W'(1);
                end
            end
            S_RESULT: begin
                if (pb1_rise) state_d = S_IDLE;
            end
            S_EARLY: begin
                if (pb1_rise) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Countdown digit from the generator count, blanked outside PREP
    always_comb begin
        digit = 2'd0;
        if (state_q == S_PREP) begin
            if (bus.counter_321 > 12'd2000)      digit = 2'd3;
            else if (bus.counter_321 > 12'd1000) digit = 2'd2;
            else if (bus.counter_321 > 12'd0)    digit = 2'd1;
            else                                 digit = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            reaction_q <= '0;
            best_q     <= MAX_T;
            new_best_q <= 1'b0;
            pb1_prev_q <= 1'b1;
            pb2_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reaction_q <= reaction_d;
            best_q     <= best_d;
            new_best_q <= new_best_d;
            pb1_prev_q <= bus.pushButton1;
            pb2_prev_q <= bus.pushButton2;
        end
    end

    assign bus.fState         = state_q;
    assign bus.countdownDigit = digit;
    assign bus.stimulusLed    = (state_q == S_TEST);
    assign bus.tooEarly       = (state_q == S_EARLY);
    assign bus.reactionTime   = reaction_q;
    assign bus.bestTime       = best_q;
    assign bus.newBest        = new_best_q;
endmodule

// File: tb/tb_reaction_fsm.sv
// Directed bench for reaction_fsm: a per-cycle vector table for countdown,
// early-press and edge-detection behaviour, plus hand-written rounds for
// timing, timeout, best tracking and mid-test reset.
module tb_reaction_fsm;
    localparam int unsigned TIME_W = 14;
    localparam int unsigned NVEC   = 24;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reaction_fsm_if #(.TIME_W(TIME_W)) bus ();

    reaction_fsm #(.MAX_TIME(9999), .TIME_W(TIME_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        pb1;
        logic        pb2;
        logic [11:0] cnt;
        logic [12:0] rnd;
        logic [2:0]  st;
        logic [1:0]  dig;
        logic        led;
        logic        early;
        logic [13:0] react;
        logic [13:0] best;
        logic        nb;
    } vec_t;

    vec_t vecs [NVEC];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.pushButton1 = 1'b0;
        bus.pushButton2 = 1'b0;
        bus.counter_321 = 12'd3000;
        bus.randomTime  = 13'd0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic enter_test_fast(input string tag);
        bus.counter_321 = 12'd3000;
        bus.randomTime  = 13'd0;
        bus.pushButton1 = 1'b1;
        tick();
        chk({tag, "_prep"}, 32'(bus.fState), 32'd1);
        bus.pushButton1 = 1'b0;
        bus.counter_321 = 12'd0;
        tick();
        chk({tag, "_test"}, 32'(bus.fState), 32'd2);
    endtask

    task automatic ack(input string tag);
        bus.pushButton1 = 1'b1;
        tick();
        chk({tag, "_idle"}, 32'(bus.fState), 32'd0);
        bus.pushButton1 = 1'b0;
        tick();
    endtask

    task automatic round(input int n, input int exp_best, input logic exp_nb, input string tag);
        enter_test_fast(tag);
        repeat (n) tick();
        bus.pushButton2 = 1'b1;
        tick();
        chk({tag, "_state"}, 32'(bus.fState), 32'd3);
        chk({tag, "_react"}, 32'(bus.reactionTime), 32'(n));
        chk({tag, "_best"}, 32'(bus.bestTime), 32'(exp_best));
        chk({tag, "_newbest"}, 32'(bus.newBest), 32'(exp_nb));
        bus.pushButton2 = 1'b0;
        tick();
        chk({tag, "_newbest_off"}, 32'(bus.newBest), 32'd0);
        ack(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.pushButton1 = 1'b0;
        bus.pushButton2 = 1'b0;
        bus.counter_321 = 12'd3000;
        bus.randomTime  = 13'd0;

        //            pb1   pb2   cnt       rnd     st    dig   led   early react    best       nb
        vecs[0]  = '{1'b0, 1'b0, 12'd3000, 13'd0,  3'd0, 2'd0, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 12'd3000, 13'd0,  3'd1, 2'd3, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 12'd2001, 13'd5,  3'd1, 2'd3, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 12'd2000, 13'd5,  3'd1, 2'd2, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 12'd1001, 13'd5,  3'd1, 2'd2, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 12'd1000, 13'd5,  3'd1, 2'd1, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 12'd1,    13'd5,  3'd1, 2'd1, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 12'd0,    13'd5,  3'd1, 2'd0, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 12'd1500, 13'd5,  3'd4, 2'd0, 1'b0, 1'b1, 14'd0, 14'd9999, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 12'd1500, 13'd5,  3'd4, 2'd0, 1'b0, 1'b1, 14'd0, 14'd9999, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 12'd1500, 13'd5,  3'd0, 2'd0, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 12'd3000, 13'd0,  3'd0, 2'd0, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 12'd3000, 13'd0,  3'd0, 2'd0, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 12'd3000, 13'd0,  3'd1, 2'd3, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 12'd0,    13'd0,  3'd4, 2'd0, 1'b0, 1'b1, 14'd0, 14'd9999, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 12'd0,    13'd0,  3'd0, 2'd0, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 12'd3000, 13'd0,  3'd0, 2'd0, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 12'd3000, 13'd0,  3'd1, 2'd3, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 12'd3000, 13'd0,  3'd1, 2'd3, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 12'd500,  13'd10, 3'd1, 2'd1, 1'b0, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 12'd2,    13'd0,  3'd2, 2'd0, 1'b1, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 12'd2,    13'd0,  3'd2, 2'd0, 1'b1, 1'b0, 14'd0, 14'd9999, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 12'd2,    13'd0,  3'd3, 2'd0, 1'b0, 1'b0, 14'd1, 14'd1,    1'b1};
        vecs[23] = '{1'b1, 1'b0, 12'd2,    13'd0,  3'd0, 2'd0, 1'b0, 1'b0, 14'd1, 14'd1,    1'b0};

        // Reset values
        tick();
        tick();
        chk("rst_state", 32'(bus.fState), 32'd0);
        chk("rst_react", 32'(bus.reactionTime), 32'd0);
        chk("rst_best", 32'(bus.bestTime), 32'd9999);
        chk("rst_newbest", 32'(bus.newBest), 32'd0);
        chk("rst_digit", 32'(bus.countdownDigit), 32'd0);
        chk("rst_led", 32'(bus.stimulusLed), 32'd0);
        chk("rst_early", 32'(bus.tooEarly), 32'd0);
        rst = 1'b0;
        tick();

        // Vector table
        for (int i = 0; i < int'(NVEC); i++) begin
            bus.pushButton1 = vecs[i].pb1;
            bus.pushButton2 = vecs[i].pb2;
            bus.counter_321 = vecs[i].cnt;
            bus.randomTime  = vecs[i].rnd;
            tick();
            chk($sformatf("v%0d_state", i), 32'(bus.fState), 32'(vecs[i].st));
            chk($sformatf("v%0d_digit", i), 32'(bus.countdownDigit), 32'(vecs[i].dig));
            chk($sformatf("v%0d_led", i), 32'(bus.stimulusLed), 32'(vecs[i].led));
            chk($sformatf("v%0d_early", i), 32'(bus.tooEarly), 32'(vecs[i].early));
            chk($sformatf("v%0d_react", i), 32'(bus.reactionTime), 32'(vecs[i].react));
            chk($sformatf("v%0d_best", i), 32'(bus.bestTime), 32'(vecs[i].best));
            chk($sformatf("v%0d_newbest", i), 32'(bus.newBest), 32'(vecs[i].nb));
        end

        // Normal round with a modelled generator: countdown then random delay
        do_reset();
        bus.counter_321 = 12'd3000;
        bus.randomTime  = 13'd0;
        bus.pushButton1 = 1'b1;
        tick();
        chk("norm_prep", 32'(bus.fState), 32'd1);
        bus.pushButton1 = 1'b0;
        bus.randomTime  = 13'd2500;
        for (int c = 2999; c >= 0; c--) begin
            bus.counter_321 = 12'(c);
            tick();
        end
        chk("norm_still_prep", 32'(bus.fState), 32'd1);
        for (int r = 2499; r >= 0; r--) begin
            bus.randomTime = 13'(r);
            tick();
        end
        chk("norm_test", 32'(bus.fState), 32'd2);
        chk("norm_led", 32'(bus.stimulusLed), 32'd1);
        repeat (237) tick();
        bus.pushButton2 = 1'b1;
        tick();
        chk("norm_result", 32'(bus.fState), 32'd3);
        chk("norm_react", 32'(bus.reactionTime), 32'd237);
        chk("norm_best", 32'(bus.bestTime), 32'd237);
        chk("norm_newbest", 32'(bus.newBest), 32'd1);
        chk("norm_led_off", 32'(bus.stimulusLed), 32'd0);
        bus.pushButton2 = 1'b0;
        tick();
        chk("norm_newbest_off", 32'(bus.newBest), 32'd0);
        ack("norm");

        // Timeout: no press, counter saturates at MAX_TIME
        enter_test_fast("tmo");
        repeat (9999) tick();
        chk("tmo_still_test", 32'(bus.fState), 32'd2);
        tick();
        chk("tmo_result", 32'(bus.fState), 32'd3);
        chk("tmo_react", 32'(bus.reactionTime), 32'd9999);
        chk("tmo_best", 32'(bus.bestTime), 32'd237);
        chk("tmo_newbest", 32'(bus.newBest), 32'd0);
        ack("tmo");

        // Best tracking over three rounds
        do_reset();
        round(300, 300, 1'b1, "r1");
        round(410, 300, 1'b0, "r2");
        round(250, 250, 1'b1, "r3");

        // Reset mid-TEST with pb2 held through reset
        enter_test_fast("mid");
        repeat (120) tick();
        bus.pushButton2 = 1'b1;
        rst = 1'b1;
        tick();
        chk("mid_state", 32'(bus.fState), 32'd0);
        chk("mid_led", 32'(bus.stimulusLed), 32'd0);
        chk("mid_react", 32'(bus.reactionTime), 32'd0);
        chk("mid_best", 32'(bus.bestTime), 32'd9999);
        chk("mid_newbest", 32'(bus.newBest), 32'd0);
        rst = 1'b0;
        bus.counter_321 = 12'd1500;
        bus.randomTime  = 13'd100;
        tick();
        bus.pushButton1 = 1'b1;
        tick();
        chk("mid_prep", 32'(bus.fState), 32'd1);
        bus.pushButton1 = 1'b0;
        tick();
        chk("mid_no_edge", 32'(bus.fState), 32'd1);
        chk("mid_no_early", 32'(bus.tooEarly), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
